nn_top: RTL and testbench

- Small fixed-weight neural-network inference core: 4 signed inputs, a hidden layer of 4 ReLU neurons and an output layer of 4 neurons.
- The argmax of the output layer selects class 0..3.
- The class digit drives a 7-segment pattern on `final[6:0]`.
- Sits at the top of the FPGA demo; `final` goes straight to the display pins.

---
 rtl/nn_top.sv | 180 ++++++++++++++++++
 tb/tb_nn_top.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/nn_top.sv
// nn_top -- fixed-weight 4-4-4 neural-network inference core with 7-segment output.
//
// A start request in IDLE latches four signed 8-bit features. The core then
// evaluates one hidden ReLU neuron per cycle (4 cycles), one output neuron per
// cycle (4 cycles), and finally picks the argmax of the outputs and shows the
// winning class digit on a 7-segment pattern.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        inference request, sampled only while idle
//   x0_i..x3_i     signed two's-complement input features (8 bits each)
//   busy_o         high whenever the core is not idle
//   done_o         one-cycle pulse when final_o is updated
//   final_o        segments {g,f,e,d,c,b,a}, active-high; blank after reset
module nn_top (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic signed [7:0] x0_i,
  input  logic signed [7:0] x1_i,
  input  logic signed [7:0] x2_i,
  input  logic signed [7:0] x3_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [6:0]       final_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HIDDEN = 2'd1,
    S_OUTPUT = 2'd2,
    S_ARGMAX = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic signed [7:0] x_q [4];
  logic signed [7:0] x_d [4];
  logic signed [11:0] h_q [4];
  logic signed [11:0] h_d [4];
  logic signed [11:0] y_q [4];
  logic signed [11:0] y_d [4];
  logic [6:0]        final_q, final_d;
  logic              done_q, done_d;

  // Weight rows packed as {w3,w2,w1,w0}, each a 3-bit signed value.
  function automatic logic [11:0] hid_row(input logic [1:0] n);
    case (n)
      2'd0:    hid_row = 12'b000_000_001_001;  // [ 1,  1,  0,  0]
      2'd1:    hid_row = 12'b000_111_001_000;  // [ 0,  1, -1,  0]
      2'd2:    hid_row = 12'b001_001_000_000;  // [ 0,  0,  1,  1]
      default: hid_row = 12'b111_000_000_001;  // [ 1,  0,  0, -1]
    endcase
  endfunction

  function automatic logic [11:0] out_row(input logic [1:0] n);
    case (n)
      2'd0:    out_row = 12'b000_000_000_010;  // [ 2,  0,  0,  0]
      2'd1:    out_row = 12'b000_000_010_000;  // [ 0,  2,  0,  0]
      2'd2:    out_row = 12'b001_001_000_000;  // [ 0,  0,  1,  1]
      default: out_row = 12'b001_000_111_001;  // [ 1, -1,  0,  1]
    endcase
  endfunction

  // Four combinational products summed in 12 bits; operand magnitudes keep
  // every partial sum well inside the signed 12-bit range.
  function automatic logic signed [11:0] dot4(input logic [11:0] row,
                                              input logic [47:0] ops);
    logic signed [11:0] acc;
    logic signed [11:0] op;
    logic signed [11:0] w;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      op  = ops[12*k +: 12];
      w   = {{9{row[3*k+2]}}, row[3*k +: 3]};
      acc = acc + op * w;
    end
    return acc;
  endfunction

  function automatic logic signed [11:0] relu(input logic signed [11:0] v);
    return v[11] ? 12'sd0 : v;
  endfunction

  function automatic logic [6:0] seg7(input logic [1:0] cls);
    case (cls)
      2'd0:    seg7 = 7'h3F;
      2'd1:    seg7 = 7'h06;
      2'd2:    seg7 = 7'h5B;
      default: seg7 = 7'h4F;
    endcase
  endfunction

  logic [47:0]        x_pack;
  logic [47:0]        h_pack;
  logic [1:0]         best_idx;
  logic signed [11:0] best_val;

  always_comb begin
    x_pack = {{{4{x_q[3][7]}}, x_q[3]}, {{4{x_q[2][7]}}, x_q[2]},
              {{4{x_q[1][7]}}, x_q[1]}, {{4{x_q[0][7]}}, x_q[0]}};
    h_pack = {h_q[3], h_q[2], h_q[1], h_q[0]};

    // Strict greater-than keeps the lowest index on ties.
    best_idx = 2'd0;
    best_val = y_q[0];
    for (int j = 1; j < 4; j++) begin
      if (y_q[j] > best_val) begin
        best_val = y_q[j];
        best_idx = 2'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    h_d     = h_q;
    y_d     = y_q;
    final_d = final_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          x_d[0]  = x0_i;
          x_d[1]  = x1_i;
          x_d[2]  = x2_i;
          x_d[3]  = x3_i;
          idx_d   = 2'd0;
          state_d = S_HIDDEN;
        end
      end
      S_HIDDEN: begin
        h_d[idx_q] = relu(dot4(hid_row(idx_q), x_pack));
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        y_d[idx_q] = dot4(out_row(idx_q), h_pack);
        idx_d      = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = S_ARGMAX;
      end
      default: begin
        final_d = seg7(best_idx);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      final_q <= 7'h00;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      final_q <= final_d;
      done_q  <= done_d;
      x_q     <= x_d;
      h_q     <= h_d;
      y_q     <= y_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = done_q;
  assign final_o = final_q;

endmodule

// File: tb/tb_nn_top.sv
// Directed testbench for nn_top: hand-computed class results, 9-edge latency,
// start ignored while busy, back-to-back starts and mid-inference reset abort.
module tb_nn_top;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic signed [7:0] x0, x1, x2, x3;
  logic             busy;
  logic             done;
  logic [6:0]       seg;

  int n_checks = 0;
  int n_errors = 0;

  nn_top dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .x0_i    (x0),
    .x1_i    (x1),
    .x2_i    (x2),
    .x3_i    (x3),
    .busy_o  (busy),
    .done_o  (done),
    .final_o (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge. Issues start, scrambles inputs
  // after the start edge, optionally pulses start at E3, and returns 1 time
  // unit after the done edge (or after the cycle budget runs out).
  task automatic run(input string tag,
                     input logic signed [7:0] a, input logic signed [7:0] b,
                     input logic signed [7:0] c, input logic signed [7:0] d,
                     input logic [6:0] exp_seg, input bit pulse_e3);
    int lat;
    x0 = a; x1 = b; x2 = c; x3 = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom); x3 = 8'($urandom);
    check({tag, "_busy_e0"}, 12'(busy), 12'd1);
    check({tag, "_done_e0"}, 12'(done), 12'd0);
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (pulse_e3 && e == 3) start = 1'b1;
      if (pulse_e3 && e == 4) start = 1'b0;
      if (done) begin
        lat = e;
        break;
      end
    end
    check({tag, "_latency"}, 12'(lat), 12'd9);
    check({tag, "_final"}, 12'(seg), 12'(exp_seg));
    check({tag, "_busy_done"}, 12'(busy), 12'd0);
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check({tag, "_no_done"}, 12'(pulses), 12'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_final", 12'(seg), 12'h00);
    check("rst_busy", 12'(busy), 12'd0);
    check("rst_done", 12'(done), 12'd0);
    @(posedge clk); #1;

    // y=[20,0,0,20]: tie resolves to class 0
    run("tie", 8'sd10, 8'sd0, 8'sd0, 8'sd0, 7'h3F, 1'b0);
    @(posedge clk); #1;
    check("tie_pulse_len", 12'(done), 12'd0);

    // y=[0,50,0,-25]
    run("c1", -8'sd10, 8'sd5, -8'sd20, 8'sd0, 7'h06, 1'b0);
    @(posedge clk); #1;

    // y=[0,0,20,0], with a stray start at E3
    run("c2", 8'sd0, 8'sd0, 8'sd10, 8'sd10, 7'h5B, 1'b1);
    quiet_cycles("c2", 12);
    check("c2_hold", 12'(seg), 12'h5B);

    // y=[40,0,50,70]
    run("c3", 8'sd20, 8'sd0, 8'sd0, -8'sd30, 7'h4F, 1'b0);
    @(posedge clk); #1;

    // Extremes, second run started in the cycle right after done.
    run("ext1", 8'sd127, 8'sd127, -8'sd128, -8'sd128, 7'h06, 1'b0);
    run("ext2", -8'sd128, -8'sd128, 8'sd127, -8'sd128, 7'h3F, 1'b0);
    @(posedge clk); #1;

    // Abort: reset asserted just after E5
    x0 = 8'sd20; x1 = 8'sd0; x2 = 8'sd0; x3 = 8'sd10;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_final", 12'(seg), 12'h00);
    check("abort_busy", 12'(busy), 12'd0);
    check("abort_done", 12'(done), 12'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    quiet_cycles("abort", 12);
    check("abort_still_blank", 12'(seg), 12'h00);

    run("after_abort", 8'sd20, 8'sd0, 8'sd0, -8'sd30, 7'h4F, 1'b0);
    @(posedge clk); #1;
    check("after_abort_pulse_len", 12'(done), 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
